// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, state type and helpers for the programmable divider
package clk_div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DIV_MIN   = 2;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_PEND = 1'b1
  } ratio_state_e;

  // Cycles spent low in one period: ceil(n/2).
  function automatic int unsigned half_ceil(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_prog_n_if.sv
// rtl/clk_div_prog_n_if.sv - ratio request/acknowledge bundle for the programmable divider
interface clk_div_prog_n_if
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             busy;

  modport master (
    output div_val,
    output div_load,
    input  div_ack,
    input  div_err,
    input  busy
  );

  modport slave (
    input  div_val,
    input  div_load,
    output div_ack,
    output div_err,
    output busy
  );

endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// rtl/clk_div_ratio_ctrl.sv - holds a pending divide ratio until the counter wraps
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_prog_n_if.slave  ctl,
  input  logic             wrap_i,
  output logic             apply_o,
  output logic [WIDTH-1:0] n_pend_o
);

  ratio_state_e     state_q, state_d;
  logic [WIDTH-1:0] n_pend_q, n_pend_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  assign apply_o  = (state_q == RS_PEND) && wrap_i;
  assign n_pend_o = n_pend_q;
  assign ctl.busy    = (state_q == RS_PEND);
  assign ctl.div_ack = ack_q;
  assign ctl.div_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RS_IDLE;
      n_pend_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_pend_q <= n_pend_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // A request landing on the apply cycle overrides the return to idle.
  always_comb begin
    state_d  = state_q;
    n_pend_d = n_pend_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    if (apply_o) begin
      state_d = RS_IDLE;
      ack_d   = 1'b1;
    end
    if (ctl.div_load) begin
      if (ctl.div_val < WIDTH'(DIV_MIN)) begin
        err_d = 1'b1;
      end else begin
        n_pend_d = ctl.div_val;
        state_d  = RS_PEND;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog_n.sv
// rtl/clk_div_prog_n.sv - glitch-free programmable integer clock divider, low phase first
module clk_div_prog_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_div_prog_n_if.slave ctl,
  output logic            clk_out,
  output logic            clk_en
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_cur_q, n_cur_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic [WIDTH-1:0] n_pend;
  logic [WIDTH-1:0] h;
  logic             wrap;
  logic             apply;

  assign wrap = (cnt_q == n_cur_q - WIDTH'(1));
  assign h    = WIDTH'(half_ceil(32'(n_cur_q)));

  clk_div_ratio_ctrl #(
    .WIDTH (WIDTH)
  ) u_ratio_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctl      (ctl),
    .wrap_i   (wrap),
    .apply_o  (apply),
    .n_pend_o (n_pend)
  );

  // New ratio and counter restart share the wrap edge, so no partial period exists.
  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + WIDTH'(1);
    n_cur_d   = apply ? n_pend : n_cur_q;
    clk_out_d = (cnt_q >= h);
    clk_en_d  = (cnt_q == h);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      n_cur_q   <= WIDTH'(DEFAULT_DIV);
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_cur_q   <= n_cur_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign clk_out = clk_out_q;
  assign clk_en  = clk_en_q;

endmodule

// File: tb/tb_clk_div_prog_n.sv
// tb/tb_clk_div_prog_n.sv - directed checks of divider waveforms and ratio handshake
module tb_clk_div_prog_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_out;
  logic clk_en;

  int checks = 0;
  int errors = 0;

  logic [15:0] vo, ve, va, vr, vb;

  clk_div_prog_n_if #(.WIDTH(8)) bus ();

  clk_div_prog_n #(
    .WIDTH       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctl     (bus.slave),
    .clk_out (clk_out),
    .clk_en  (clk_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Run n cycles; each vector holds one sample per cycle, oldest sample in the highest used bit.
  task automatic run(input int n);
    vo = '0; ve = '0; va = '0; vr = '0; vb = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.div_load = 1'b0;
      vo = {vo[14:0], clk_out};
      ve = {ve[14:0], clk_en};
      va = {va[14:0], bus.div_ack};
      vr = {vr[14:0], bus.div_err};
      vb = {vb[14:0], bus.busy};
    end
  endtask

  task automatic request(input logic [7:0] val);
    bus.div_val  = val;
    bus.div_load = 1'b1;
  endtask

  initial begin
    bus.div_val  = '0;
    bus.div_load = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", {27'd0, clk_out, clk_en, bus.busy, bus.div_ack, bus.div_err}, 32'h0);
    rst_n = 1'b1;

    // Default N=4 free run
    run(12);
    check_eq("t1_out",  vo, 32'h333);
    check_eq("t1_en",   ve, 32'h222);
    check_eq("t1_ack",  va, 32'h0);
    check_eq("t1_busy", vb, 32'h0);

    // N=5 requested mid-period
    run(1);
    request(8'd5);
    run(12);
    check_eq("t2_busy", vb, 32'hC00);
    check_eq("t2_ack",  va, 32'h200);
    check_eq("t2_out",  vo, 32'h631);
    check_eq("t2_en",   ve, 32'h421);
    check_eq("t2_err",  vr, 32'h0);

    // div_val=1 rejected, ratio stays 5
    request(8'd1);
    run(10);
    check_eq("t3_err",  vr, 32'h200);
    check_eq("t3_ack",  va, 32'h0);
    check_eq("t3_busy", vb, 32'h0);
    check_eq("t3_out",  vo, 32'h231);

    // 6 then 3 while busy: only 3 applied, single ack
    run(1);
    request(8'd6);
    run(1);
    check_eq("t4_busy_first", {31'd0, vb[0]}, 32'h1);
    request(8'd3);
    run(12);
    check_eq("t4_busy", vb, 32'hE00);
    check_eq("t4_ack",  va, 32'h100);
    check_eq("t4_out",  vo, 32'h324);
    check_eq("t4_en",   ve, 32'h224);

    // Request on the wrap cycle: applied at the following wrap
    request(8'd2);
    run(10);
    check_eq("t5_busy", vb, 32'h380);
    check_eq("t5_ack",  va, 32'h040);
    check_eq("t5_out",  vo, 32'h255);
    check_eq("t5_en",   ve, 32'h255);

    // Reset while a request for 7 is pending
    request(8'd7);
    run(1);
    check_eq("t6_busy_pre", {31'd0, vb[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async", {27'd0, clk_out, clk_en, bus.busy, bus.div_ack, bus.div_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(12);
    check_eq("t6_out",  vo, 32'h333);
    check_eq("t6_en",   ve, 32'h222);
    check_eq("t6_ack",  va, 32'h0);
    check_eq("t6_busy", vb, 32'h0);
    check_eq("t6_err",  vr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
